modexp_operand_loader: RTL

Upstream feeder for the modular-exponentiation core. It assembles the three OP_W-bit operands (ciphertext key, exponent, modulus) from a narrow WORD_W-bit valid/ready word stream, then pulses start to the core. It holds the operands stable until the core reports done, then re-arms for the next job.

---
 rtl/rsa_pkg.sv | 32 +++
 rtl/modexp_operand_reg.sv | 32 +++
 rtl/modexp_operand_loader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared types and defaults for the modular-exponentiation operand loader.
// Holds operand/word widths, the operand-select and loader-state enums.
package rsa_pkg;

    localparam int OP_W_DEF   = 4096;
    localparam int WORD_W_DEF = 32;
    localparam int NWORDS     = OP_W_DEF / WORD_W_DEF;

    typedef enum logic [1:0] {
        SEL_KEY  = 2'd0,
        SEL_EXP  = 2'd1,
        SEL_MOD  = 2'd2,
        SEL_RSVD = 2'd3
    } op_sel_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } ld_state_e;

    // Loaded-mask bit position for an operand select; reserved maps to no bit.
    function automatic logic [2:0] sel_onehot(input op_sel_e s);
        case (s)
            SEL_KEY: sel_onehot = 3'b001;
            SEL_EXP: sel_onehot = 3'b010;
            SEL_MOD: sel_onehot = 3'b100;
            default: sel_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/modexp_operand_reg.sv
// One OP_W-bit operand register: first-word write clears the upper words,
// later writes fill the slice addressed by the word index, otherwise it holds.
module modexp_operand_reg #(
    parameter int OP_W   = 4096,
    parameter int WORD_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_clr,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [WORD_W-1:0] i_word,
    output logic [OP_W-1:0]   o_q
);

    logic [OP_W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_we) begin
            if (i_clr)
                r_q <= {{(OP_W-WORD_W){1'b0}}, i_word};
            else
                r_q[i_idx*WORD_W +: WORD_W] <= i_word;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/modexp_operand_loader.sv
// Assembles key/exp/mod from a WORD_W valid/ready stream and launches the core.
// Optional macro MODEXP_LOADER_ZEROCHK_EN rejects a launch whose modulus is zero.
module modexp_operand_loader
    import rsa_pkg::*;
#(
    parameter int OP_W   = OP_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic [OP_W-1:0]   key_o,
    output logic [OP_W-1:0]   exp_o,
    output logic [OP_W-1:0]   mod_o,
    output logic              start_o,
    input  logic              done_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int NW    = OP_W / WORD_W;
    localparam int CNT_W = $clog2(NW) + 1;

    ld_state_e          r_state, w_state_nxt;
    logic [2:0]         r_mask, w_mask_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_open;
    op_sel_e            r_sel;
    logic               r_err;

    logic               w_xfer, w_first, w_rsvd, w_wr, w_close;
    logic               w_mask_clr, w_zero_err;
    op_sel_e            w_sel_in, w_tgt;
    logic [CNT_W-1:0]   w_idx, w_cnt_inc;
    logic [2:0]         w_tgt_oh;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign w_xfer    = in_valid && in_ready;
    assign w_sel_in  = op_sel_e'(in_sel);
    assign w_first   = w_xfer && !r_open;
    assign w_rsvd    = w_first && (w_sel_in == SEL_RSVD);
    assign w_wr      = w_xfer && !w_rsvd;
    assign w_tgt     = w_first ? w_sel_in : r_sel;
    assign w_tgt_oh  = sel_onehot(w_tgt);
    assign w_idx     = w_first ? '0 : r_cnt;
    assign w_cnt_inc = w_idx + CNT_W'(1);
    assign w_close   = w_wr && (in_last || (w_cnt_inc == CNT_W'(NW)));

    // A reload drops the mask bit at its first word; the closing word sets it.
    assign w_mask_nxt = (r_mask & ~((w_wr && w_first) ? w_tgt_oh : 3'b000))
                      | (w_close ? w_tgt_oh : 3'b000);

`ifdef MODEXP_LOADER_ZEROCHK_EN
    logic w_mod_nz_nxt;
    // Modulus non-zero test on the value the register will hold after this edge.
    assign w_mod_nz_nxt = (w_wr && (w_tgt == SEL_MOD))
                        ? ((!w_first && (|mod_o)) || (|in_data))
                        : (|mod_o);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_mask_clr  = 1'b0;
        w_zero_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mask_nxt == 3'b111) begin
`ifdef MODEXP_LOADER_ZEROCHK_EN
                    if (!w_mod_nz_nxt) begin
                        w_mask_clr = 1'b1;
                        w_zero_err = 1'b1;
                    end else begin
                        w_state_nxt = LAUNCH;
                    end
`else
                    w_state_nxt = LAUNCH;
`endif
                end
            end
            LAUNCH: w_state_nxt = WAIT;
            WAIT: begin
                if (done_i) begin
                    w_state_nxt = IDLE;
                    w_mask_clr  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_mask  <= 3'b000;
            r_cnt   <= '0;
            r_open  <= 1'b0;
            r_sel   <= SEL_KEY;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_clr ? 3'b000 : w_mask_nxt;
            if (w_wr) begin
                r_cnt  <= w_close ? '0 : w_cnt_inc;
                r_open <= !w_close;
            end
            if (w_first && !w_rsvd)
                r_sel <= w_sel_in;
            if (w_rsvd || w_zero_err)
                r_err <= 1'b1;
        end
    end

    modexp_operand_reg #(.OP_W(OP_W), .WORD_W(WORD_W), .IDX_W(CNT_W)) u_key (
        .clk(clk), .rst(rst),
        .i_we(w_wr && (w_tgt == SEL_KEY)), .i_clr(w_first),
        .i_idx(w_idx), .i_word(in_data), .o_q(key_o)
    );

    modexp_operand_reg #(.OP_W(OP_W), .WORD_W(WORD_W), .IDX_W(CNT_W)) u_exp (
        .clk(clk), .rst(rst),
        .i_we(w_wr && (w_tgt == SEL_EXP)), .i_clr(w_first),
        .i_idx(w_idx), .i_word(in_data), .o_q(exp_o)
    );

    modexp_operand_reg #(.OP_W(OP_W), .WORD_W(WORD_W), .IDX_W(CNT_W)) u_mod (
        .clk(clk), .rst(rst),
        .i_we(w_wr && (w_tgt == SEL_MOD)), .i_clr(w_first),
        .i_idx(w_idx), .i_word(in_data), .o_q(mod_o)
    );

    assign start_o = (r_state == LAUNCH);
    assign busy_o  = (r_state == LAUNCH) || (r_state == WAIT);
    assign err_o   = r_err;

endmodule
